// File: rtl/deadlock_pkg.sv
// Shared types and helpers for the deadlock report collector.
// Holds the controller state encoding, the process-ID width derivation
// and the lowest-set-bit priority picker used for both detect and token vectors.
package deadlock_pkg;

  // Widest process vector the priority picker accepts; callers zero-extend into it.
  localparam int MAX_PROC = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    TRACE = 3'd2,
    DUMP  = 3'd3,
    DONE  = 3'd4
  } dlState_e;

  // Width of a process ID; never narrower than one bit.
  function automatic int pidWidth(input int procNum);
    return (procNum > 1) ? $clog2(procNum) : 1;
  endfunction

  // Index of the lowest set bit; returns 0 for an all-zero vector,
  // so callers must qualify the result with a non-zero check.
  function automatic int lowestSetIdx(input logic [MAX_PROC-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_PROC - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/deadlock_path_buf.sv
// Path trace buffer: MAX_PATH entries of process IDs written in visit order
// and read back in the same order. Only the pointers are reset; the storage
// is always written before it is read, so it carries no reset.
module deadlock_path_buf #(
  parameter int MAX_PATH = 16,
  parameter int PID_W    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ptrClear_i,
  input  logic             wrEn_i,
  input  logic [PID_W-1:0] wrData_i,
  input  logic             rdAdv_i,
  output logic [PID_W-1:0] rdData_o,
  output logic             full_o,
  output logic             oneLeft_o,
  output logic             rdLast_o
);

  // Pointers count entries, so they need one value beyond the last index.
  localparam int PTR_W = $clog2(MAX_PATH + 1);
  localparam int AW    = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;

  logic [PID_W-1:0] mem [MAX_PATH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic             wrOk;

  // Writes past the last slot are dropped, so entry MAX_PATH+1 can never land.
  assign wrOk = wrEn_i && !full_o;

  // Pointer bookkeeping: cleared on reset or when a fresh trace starts.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else if (ptrClear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (wrOk)    wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (rdAdv_i) rdPtr_q <= rdPtr_q + PTR_W'(1);
    end
  end

  // Entry storage: one slot written per accepted append.
  always_ff @(posedge clock) begin
    if (wrOk) mem[wrPtr_q[AW-1:0]] <= wrData_i;
  end

  assign rdData_o  = mem[rdPtr_q[AW-1:0]];
  assign full_o    = (wrPtr_q == PTR_W'(MAX_PATH));
  assign oneLeft_o = (wrPtr_q == PTR_W'(MAX_PATH - 1));
  assign rdLast_o  = (rdPtr_q == (wrPtr_q - PTR_W'(1)));

endmodule

// File: rtl/deadlock_report_ctrl.sv
// Deadlock report collector: picks an origin process from the detect flags,
// fires the origin pulse, follows the report token around the dependence
// cycle, stops it, then streams the visited process IDs to the reporter.
module deadlock_report_ctrl
  import deadlock_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int MAX_PATH = 16,
  parameter int TIMEOUT  = 1024,
  parameter int PID_W    = pidWidth(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  input  logic                clear,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                deadlock,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [PID_W-1:0]    rpt_pid,
  output logic                rpt_last,
  output logic                rpt_trunc
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  dlState_e            state_q, state_d;
  logic [PID_W-1:0]    orgId_q, orgId_d;
  logic [CNT_W-1:0]    tmoCnt_q, tmoCnt_d;
  logic [PROC_NUM-1:0] originVec_q, originVec_d;
  logic                dlDetect_q, dlDetect_d;
  logic                deadlock_q, deadlock_d;
  logic                trunc_q, trunc_d;
  logic                rptValid_q, rptValid_d;

  logic [PID_W-1:0]    detIdx;
  logic [PID_W-1:0]    tokIdx;
  logic                tokSeen;
  logic                retHit;
  logic                tmoHit;
  logic                appendHit;
  logic                bufWrEn;
  logic [PID_W-1:0]    bufWrData;
  logic                bufRdAdv;
  logic [PID_W-1:0]    bufRdData;
  logic                bufFull;
  logic                bufOneLeft;
  logic                bufRdLast;

  deadlock_path_buf #(
    .MAX_PATH (MAX_PATH),
    .PID_W    (PID_W)
  ) u_pathBuf (
    .clock      (clock),
    .reset      (reset),
    .ptrClear_i (state_q == IDLE),
    .wrEn_i     (bufWrEn),
    .wrData_i   (bufWrData),
    .rdAdv_i    (bufRdAdv),
    .rdData_o   (bufRdData),
    .full_o     (bufFull),
    .oneLeft_o  (bufOneLeft),
    .rdLast_o   (bufRdLast)
  );

  // Trace decisions: a token back at the origin ends the trace cleanly and
  // wins over both a filling buffer and an expiring timeout.
  always_comb begin
    detIdx    = PID_W'(lowestSetIdx(MAX_PROC'(dl_detect_vec)));
    tokIdx    = PID_W'(lowestSetIdx(MAX_PROC'(token_vec)));
    tokSeen   = |token_vec;
    retHit    = (state_q == TRACE) && tokSeen && (tokIdx == orgId_q);
    tmoHit    = (state_q == TRACE) && (tmoCnt_q == CNT_W'(TIMEOUT - 1));
    appendHit = (state_q == TRACE) && tokSeen && !retHit && !bufFull;
    bufWrEn   = (state_q == ARM) || appendHit;
    bufWrData = (state_q == ARM) ? orgId_q : tokIdx;
    bufRdAdv  = (state_q == DUMP) && rptValid_q && rpt_ready;
  end

  // Next-state and next-output selection for the collector sequence.
  always_comb begin
    state_d     = state_q;
    orgId_d     = orgId_q;
    tmoCnt_d    = tmoCnt_q;
    originVec_d = '0;
    dlDetect_d  = dlDetect_q;
    deadlock_d  = deadlock_q;
    trunc_d     = trunc_q;
    rptValid_d  = rptValid_q;
    case (state_q)
      IDLE: begin
        tmoCnt_d = '0;
        if (|dl_detect_vec) begin
          orgId_d     = detIdx;
          originVec_d = PROC_NUM'(1) << detIdx;
          dlDetect_d  = 1'b1;
          deadlock_d  = 1'b1;
          state_d     = ARM;
        end
      end
      ARM: begin
        tmoCnt_d = '0;
        state_d  = TRACE;
      end
      TRACE: begin
        tmoCnt_d = tmoCnt_q + CNT_W'(1);
        if (retHit) begin
          rptValid_d = 1'b1;
          state_d    = DUMP;
        end else if ((appendHit && bufOneLeft) || tmoHit) begin
          trunc_d    = 1'b1;
          rptValid_d = 1'b1;
          state_d    = DUMP;
        end
      end
      DUMP: begin
        if (bufRdAdv && bufRdLast) begin
          rptValid_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (clear) begin
          dlDetect_d = 1'b0;
          deadlock_d = 1'b0;
          trunc_d    = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset overrides every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      orgId_q     <= '0;
      tmoCnt_q    <= '0;
      originVec_q <= '0;
      dlDetect_q  <= 1'b0;
      deadlock_q  <= 1'b0;
      trunc_q     <= 1'b0;
      rptValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      orgId_q     <= orgId_d;
      tmoCnt_q    <= tmoCnt_d;
      originVec_q <= originVec_d;
      dlDetect_q  <= dlDetect_d;
      deadlock_q  <= deadlock_d;
      trunc_q     <= trunc_d;
      rptValid_q  <= rptValid_d;
    end
  end

  assign dl_detect_in = dlDetect_q;
  assign origin_vec   = originVec_q;
  assign token_clear  = retHit || tmoHit;
  assign deadlock     = deadlock_q;
  assign rpt_valid    = rptValid_q;
  assign rpt_pid      = rptValid_q ? bufRdData : '0;
  assign rpt_last     = rptValid_q && bufRdLast;
  assign rpt_trunc    = trunc_q;

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Directed bench for deadlock_report_ctrl with a short buffer and timeout,
// so truncation by a full buffer and by timeout are both reachable quickly.
module tb_deadlock_report_ctrl;

  localparam int PROC_NUM = 4;
  localparam int MAX_PATH = 4;
  localparam int TIMEOUT  = 8;
  localparam int PID_W    = 2;

  logic                clock;
  logic                reset;
  logic [PROC_NUM-1:0] dl_detect_vec;
  logic [PROC_NUM-1:0] token_vec;
  logic                clear;
  logic                dl_detect_in;
  logic [PROC_NUM-1:0] origin_vec;
  logic                token_clear;
  logic                deadlock;
  logic                rpt_valid;
  logic                rpt_ready;
  logic [PID_W-1:0]    rpt_pid;
  logic                rpt_last;
  logic                rpt_trunc;

  int nCompared;
  int nMismatched;

  deadlock_report_ctrl #(
    .PROC_NUM (PROC_NUM),
    .MAX_PATH (MAX_PATH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dl_detect_vec (dl_detect_vec),
    .token_vec     (token_vec),
    .clear         (clear),
    .dl_detect_in  (dl_detect_in),
    .origin_vec    (origin_vec),
    .token_clear   (token_clear),
    .deadlock      (deadlock),
    .rpt_valid     (rpt_valid),
    .rpt_ready     (rpt_ready),
    .rpt_pid       (rpt_pid),
    .rpt_last      (rpt_last),
    .rpt_trunc     (rpt_trunc)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic applyStimulus(input logic [3:0] det, input logic [3:0] tok,
                               input logic clr, input logic rdy, input logic rst);
    @(negedge clock);
    dl_detect_vec = det;
    token_vec     = tok;
    clear         = clr;
    rpt_ready     = rdy;
    reset         = rst;
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One dump beat: entry presented, with the given ready level.
  task automatic dumpBeat(input string tag, input logic rdy, input int pid,
                          input logic last, input logic trunc);
    applyStimulus(4'b0000, 4'b0000, 1'b0, rdy, 1'b0);
    checkOutput({tag, " valid"}, rpt_valid, 1);
    checkOutput({tag, " pid"},   rpt_pid, pid);
    checkOutput({tag, " last"},  rpt_last, last);
    checkOutput({tag, " trunc"}, rpt_trunc, trunc);
  endtask

  // Sit in DONE for a cycle with clear pulsed, then confirm the re-arm.
  task automatic finishDone(input string tag);
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    checkOutput({tag, " done valid"},    rpt_valid, 0);
    checkOutput({tag, " done deadlock"}, deadlock, 1);
    checkOutput({tag, " done detin"},    dl_detect_in, 1);
    checkOutput({tag, " done tokclr"},   token_clear, 0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " clr deadlock"},  deadlock, 0);
    checkOutput({tag, " clr detin"},     dl_detect_in, 0);
    checkOutput({tag, " clr trunc"},     rpt_trunc, 0);
  endtask

  initial begin
    nCompared     = 0;
    nMismatched   = 0;
    reset         = 1'b1;
    dl_detect_vec = '0;
    token_vec     = '0;
    clear         = 1'b0;
    rpt_ready     = 1'b0;

    // Reset state.
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("reset outputs",
                {dl_detect_in, origin_vec, token_clear, deadlock,
                 rpt_valid, rpt_pid, rpt_last, rpt_trunc}, 0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Test 1: origin 2, tokens 3,0,2 -> dump 2,3,0; clear in TRACE ignored.
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("t1 idle origin", origin_vec, 0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("t1 arm origin",   origin_vec, 4'b0100);
    checkOutput("t1 arm detin",    dl_detect_in, 1);
    checkOutput("t1 arm deadlock", deadlock, 1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("t1 tr1 origin", origin_vec, 0);
    checkOutput("t1 tr1 tokclr", token_clear, 0);
    applyStimulus(4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("t1 tr2 tokclr", token_clear, 0);
    applyStimulus(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
    checkOutput("t1 tr3 tokclr", token_clear, 0);
    applyStimulus(4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("t1 tr4 tokclr", token_clear, 1);
    checkOutput("t1 tr4 valid",  rpt_valid, 0);
    dumpBeat("t1 e0", 1'b1, 2, 1'b0, 1'b0);
    dumpBeat("t1 e1", 1'b1, 3, 1'b0, 1'b0);
    dumpBeat("t1 e2", 1'b1, 0, 1'b1, 1'b0);
    finishDone("t1");

    // Test 2: two detects -> origin 1; origin-token during ARM is ignored.
    applyStimulus(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 arm origin", origin_vec, 4'b0010);
    checkOutput("t2 arm tokclr", token_clear, 0);
    applyStimulus(4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 tr1 tokclr", token_clear, 0);
    applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 tr2 tokclr", token_clear, 1);
    dumpBeat("t2 e0", 1'b1, 1, 1'b0, 1'b0);
    dumpBeat("t2 e1", 1'b1, 2, 1'b1, 1'b0);
    finishDone("t2");

    // Test 3: origin 0, tokens 1,2,3 fill the buffer; 1,2 afterwards ignored;
    // ready held low for 5 cycles on the second entry.
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("t3 arm origin", origin_vec, 4'b0001);
    applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("t3 full tokclr", token_clear, 0);
    applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0);
    checkOutput("t3 e0 valid", rpt_valid, 1);
    checkOutput("t3 e0 pid",   rpt_pid, 0);
    checkOutput("t3 e0 trunc", rpt_trunc, 1);
    checkOutput("t3 e0 tokclr", token_clear, 0);
    applyStimulus(4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("t3 stall0 pid", rpt_pid, 1);
    for (int i = 1; i < 5; i++) begin
      dumpBeat("t3 stall", 1'b0, 1, 1'b0, 1'b1);
    end
    dumpBeat("t3 e1", 1'b1, 1, 1'b0, 1'b1);
    dumpBeat("t3 e2", 1'b1, 2, 1'b0, 1'b1);
    dumpBeat("t3 e3", 1'b1, 3, 1'b1, 1'b1);
    finishDone("t3");

    // Test 4: origin 3, no token ever -> timeout on the 8th TRACE cycle.
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("t4 arm origin", origin_vec, 4'b1000);
    for (int i = 1; i <= TIMEOUT; i++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("t4 tr%0d tokclr", i), token_clear, (i == TIMEOUT) ? 1 : 0);
    end
    dumpBeat("t4 e0", 1'b1, 3, 1'b1, 1'b1);
    finishDone("t4");

    // Test 5: reset during TRACE, then a fresh detect is accepted.
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("t5 post-reset outputs",
                {dl_detect_in, origin_vec, token_clear, deadlock,
                 rpt_valid, rpt_pid, rpt_last, rpt_trunc}, 0);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("t5 arm origin", origin_vec, 4'b0100);
    applyStimulus(4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("t5 tr1 tokclr", token_clear, 1);
    dumpBeat("t5 e0", 1'b1, 2, 1'b1, 1'b0);
    finishDone("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
